// File: rtl/assoc_cache_array.sv
// N-way set-associative cache data/tag array with multi-word blocks, dirty bits,
// true-LRU replacement, dirty-victim eviction reporting and an invalidate-all walker.
module assoc_cache_array #(
    parameter int ADDR_SIZE       = 32,
    parameter int NUM_SETS        = 16,
    parameter int NUM_WAYS        = 4,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              op_valid,
    input  logic [1:0]                        op,
    input  logic [ADDR_SIZE-1:0]              addr,
    input  logic [31:0]                       wdata,
    input  logic [3:0]                        wstrb,
    input  logic [32*WORDS_PER_BLOCK-1:0]     fill_data,
    output logic                              ready,
    output logic                              resp_valid,
    output logic                              hit,
    output logic [31:0]                       rdata,
    output logic [$clog2(NUM_WAYS)-1:0]       victim_way,
    output logic                              evict_valid,
    output logic [ADDR_SIZE-1:0]              evict_addr,
    output logic [32*WORDS_PER_BLOCK-1:0]     evict_data
);

    localparam int WORD_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int WIDX_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int OFF       = 2 + WORD_BITS;
    localparam int SET_W     = $clog2(NUM_SETS);
    localparam int TAG_W     = ADDR_SIZE - SET_W - OFF;
    localparam int WAY_W     = $clog2(NUM_WAYS);
    localparam int BLK_W     = 32 * WORDS_PER_BLOCK;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [BLK_W-1:0]    data_r  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_r   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_r [NUM_SETS];
    logic [WAY_W-1:0]    age_r   [NUM_SETS][NUM_WAYS];
    logic [0:0]          state_r;
    logic [SET_W-1:0]    clear_set_r;

    logic [SET_W-1:0]    set_s;
    logic [TAG_W-1:0]    tag_s;
    logic [WIDX_W-1:0]   word_s;
    logic                accept_s;
    logic [NUM_WAYS-1:0] hit_vec_s;
    logic                hit_any_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic [WAY_W-1:0]    inv_way_s;
    logic [WAY_W-1:0]    lru_way_s;
    logic [WAY_W-1:0]    victim_s;
    logic [WAY_W-1:0]    touch_s;
    logic [WAY_W-1:0]    new_age_s [NUM_WAYS];
    logic [BLK_W-1:0]    hit_blk_s;
    logic [31:0]         old_word_s;
    logic [31:0]         merged_word_s;
    logic [BLK_W-1:0]    wr_blk_s;
    logic                unused_s;

    assign set_s    = addr[OFF +: SET_W];
    assign tag_s    = addr[ADDR_SIZE-1 -: TAG_W];
    assign word_s   = (WORD_BITS > 0) ? addr[2 +: WIDX_W] : {WIDX_W{1'b0}};
    assign ready    = (state_r == ST_IDLE);
    assign accept_s = op_valid && ready;
    assign unused_s = ^addr[1:0];

    // Tag compare, victim selection (lowest invalid way, else oldest) and LRU touch ages.
    always_comb begin
        hit_way_s = {WAY_W{1'b0}};
        inv_way_s = {WAY_W{1'b0}};
        lru_way_s = {WAY_W{1'b0}};
        hit_vec_s = {NUM_WAYS{1'b0}};
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_vec_s[w] = valid_r[set_s][w] && (tag_r[set_s][w] == tag_s);
            hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
            inv_way_s    = !valid_r[set_s][w] ? WAY_W'(w) : inv_way_s;
            lru_way_s    = (age_r[set_s][w] == WAY_W'(NUM_WAYS - 1)) ? WAY_W'(w) : lru_way_s;
        end
        hit_any_s = |hit_vec_s;
        victim_s  = (&valid_r[set_s]) ? lru_way_s : inv_way_s;
        touch_s   = ((op == OP_FILL) && !hit_any_s) ? victim_s : hit_way_s;
        for (int w = 0; w < NUM_WAYS; w++) begin
            new_age_s[w] = (WAY_W'(w) == touch_s) ? {WAY_W{1'b0}} :
                           (age_r[set_s][w] < age_r[set_s][touch_s]) ? age_r[set_s][w] + WAY_W'(1) :
                           age_r[set_s][w];
        end
    end

    // Byte-masked merge of the write word into the hitting block.
    always_comb begin
        hit_blk_s  = data_r[set_s][hit_way_s];
        old_word_s = hit_blk_s[{word_s, 5'b00000} +: 32];
        for (int b = 0; b < 4; b++) begin
            merged_word_s[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_word_s[8*b +: 8];
        end
        wr_blk_s = hit_blk_s;
        wr_blk_s[{word_s, 5'b00000} +: 32] = merged_word_s;
    end

    // Line metadata (valid/dirty/age) and the invalidate-all walker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            clear_set_r <= {SET_W{1'b0}};
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= {NUM_WAYS{1'b0}};
                dirty_r[s] <= {NUM_WAYS{1'b0}};
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_r[s][w] <= WAY_W'(w);
                end
            end
        end else if (state_r == ST_CLEAR) begin
            valid_r[clear_set_r] <= {NUM_WAYS{1'b0}};
            dirty_r[clear_set_r] <= {NUM_WAYS{1'b0}};
            for (int w = 0; w < NUM_WAYS; w++) begin
                age_r[clear_set_r][w] <= WAY_W'(w);
            end
            if (clear_set_r == SET_W'(NUM_SETS - 1)) begin
                state_r <= ST_IDLE;
            end
            clear_set_r <= clear_set_r + SET_W'(1);
        end else if (accept_s) begin
            case (op)
                OP_READ: begin
                    if (hit_any_s) begin
                        for (int w = 0; w < NUM_WAYS; w++) age_r[set_s][w] <= new_age_s[w];
                    end
                end
                OP_WRITE: begin
                    if (hit_any_s) begin
                        dirty_r[set_s][hit_way_s] <= 1'b1;
                        for (int w = 0; w < NUM_WAYS; w++) age_r[set_s][w] <= new_age_s[w];
                    end
                end
                OP_FILL: begin
                    valid_r[set_s][touch_s] <= 1'b1;
                    dirty_r[set_s][touch_s] <= 1'b0;
                    for (int w = 0; w < NUM_WAYS; w++) age_r[set_s][w] <= new_age_s[w];
                end
                OP_INV: begin
                    state_r     <= ST_CLEAR;
                    clear_set_r <= {SET_W{1'b0}};
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

    // Data and tag storage; contents are qualified by valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept_s && (op == OP_WRITE) && hit_any_s) begin
            data_r[set_s][hit_way_s] <= wr_blk_s;
        end else if (accept_s && (op == OP_FILL)) begin
            data_r[set_s][touch_s] <= fill_data;
            tag_r[set_s][touch_s]  <= tag_s;
        end
    end

    // Registered response; the walker reports one cycle before it finishes the last set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            hit         <= 1'b0;
            rdata       <= 32'h0000_0000;
            victim_way  <= {WAY_W{1'b0}};
            evict_valid <= 1'b0;
            evict_addr  <= {ADDR_SIZE{1'b0}};
            evict_data  <= {BLK_W{1'b0}};
        end else begin
            resp_valid  <= 1'b0;
            hit         <= 1'b0;
            evict_valid <= 1'b0;
            if ((state_r == ST_CLEAR) && (clear_set_r == SET_W'(NUM_SETS - 2))) begin
                resp_valid <= 1'b1;
            end else if (accept_s && (op != OP_INV)) begin
                resp_valid  <= 1'b1;
                hit         <= hit_any_s;
                rdata       <= old_word_s;
                victim_way  <= hit_any_s ? hit_way_s : victim_s;
                evict_valid <= !hit_any_s && valid_r[set_s][victim_s] && dirty_r[set_s][victim_s];
                evict_addr  <= {tag_r[set_s][victim_s], set_s, {OFF{1'b0}}};
                evict_data  <= data_r[set_s][victim_s];
            end
        end
    end

endmodule

// File: tb/tb_assoc_cache_array.sv
// Directed bench for assoc_cache_array: expectations queued at issue time and
// compared when the registered response appears.
module tb_assoc_cache_array;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;
    localparam int NS = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [1:0]   op;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [127:0] fill_data;
    logic         ready;
    logic         resp_valid;
    logic         hit;
    logic [31:0]  rdata;
    logic [1:0]   victim_way;
    logic         evict_valid;
    logic [31:0]  evict_addr;
    logic [127:0] evict_data;

    typedef struct {
        string        nm;
        logic         h;
        logic         cvw;
        logic [1:0]   vw;
        logic         crd;
        logic [31:0]  rd;
        logic         ev;
        logic         cea;
        logic [31:0]  ea;
        logic         ced;
        logic [127:0] ed;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [127:0] B1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    assoc_cache_array #(.ADDR_SIZE(32), .NUM_SETS(NS), .NUM_WAYS(4), .WORDS_PER_BLOCK(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .fill_data(fill_data), .ready(ready), .resp_valid(resp_valid),
        .hit(hit), .rdata(rdata), .victim_way(victim_way), .evict_valid(evict_valid),
        .evict_addr(evict_addr), .evict_data(evict_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, expv);
        end
    endtask

    function automatic logic [127:0] blk(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    function automatic exp_t mk(input string nm, input logic h, input logic cvw, input logic [1:0] vw,
                                input logic crd, input logic [31:0] rd, input logic ev,
                                input logic cea, input logic [31:0] ea,
                                input logic ced, input logic [127:0] ed);
        exp_t e;
        e.nm = nm; e.h = h; e.cvw = cvw; e.vw = vw; e.crd = crd; e.rd = rd;
        e.ev = ev; e.cea = cea; e.ea = ea; e.ced = ced; e.ed = ed;
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [127:0] fd, input logic push, input exp_t e);
        op = o; addr = a; wdata = wd; wstrb = ws; fill_data = fd; op_valid = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic rd_hit(input string nm, input logic [31:0] a, input logic [31:0] rd);
        issue(OP_READ, a, 32'h0, 4'h0, 128'h0, 1'b1,
              mk(nm, 1'b1, 1'b0, 2'd0, 1'b1, rd, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0));
    endtask

    task automatic rd_miss(input string nm, input logic [31:0] a, input logic [1:0] vw);
        issue(OP_READ, a, 32'h0, 4'h0, 128'h0, 1'b1,
              mk(nm, 1'b0, 1'b1, vw, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0));
    endtask

    task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic h, input logic [1:0] vw);
        issue(OP_WRITE, a, wd, ws, 128'h0, 1'b1,
              mk(nm, h, !h, vw, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0));
    endtask

    task automatic fill(input string nm, input logic [31:0] a, input logic [127:0] fd,
                        input logic h, input logic [1:0] vw);
        issue(OP_FILL, a, 32'h0, 4'h0, fd, 1'b1,
              mk(nm, h, 1'b1, vw, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0));
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard checker: pops one expectation per response pulse.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            chk("resp_pending", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_hit"}, 128'(hit), 128'(e.h));
                chk({e.nm, "_evict_valid"}, 128'(evict_valid), 128'(e.ev));
                if (e.cvw) chk({e.nm, "_victim_way"}, 128'(victim_way), 128'(e.vw));
                if (e.crd) chk({e.nm, "_rdata"}, 128'(rdata), 128'(e.rd));
                if (e.cea) chk({e.nm, "_evict_addr"}, 128'(evict_addr), 128'(e.ea));
                if (e.ced) chk({e.nm, "_evict_data"}, evict_data, e.ed);
            end
        end else if (!resp_valid) begin
            chk("idle_hit", 128'(hit), 128'd0);
            chk("idle_evict_valid", 128'(evict_valid), 128'd0);
        end
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = OP_READ; addr = 32'h0; wdata = 32'h0;
        wstrb = 4'h0; fill_data = 128'h0;
        #12;
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_resp_valid", 128'(resp_valid), 128'd0);
        chk("rst_rdata", 128'(rdata), 128'd0);
        chk("rst_victim_way", 128'(victim_way), 128'd0);
        chk("rst_evict_addr", 128'(evict_addr), 128'd0);
        chk("rst_evict_data", evict_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        rd_miss("cold_read", 32'h0000_1040, 2'd0);
        fill("fill_1040", 32'h0000_1040, B1, 1'b0, 2'd0);
        rd_hit("read_1048", 32'h0000_1048, 32'h3333_3333);
        wr("write_1044", 32'h0000_1044, 32'hDEAD_BEEF, 4'b0011, 1'b1, 2'd0);
        rd_hit("read_1044", 32'h0000_1044, 32'h2222_BEEF);
        rd_hit("read_104c", 32'h0000_104C, 32'h4444_4444);
        rd_miss("read_set5", 32'h0000_1050, 2'd0);
        fill("refill_1040", 32'h0000_1040, B1, 1'b1, 2'd0);
        rd_hit("read_1044_refilled", 32'h0000_1044, 32'h2222_2222);
        fill("fill_2040", 32'h0000_2040, blk(32'hA000_0000), 1'b0, 2'd1);
        fill("fill_3040", 32'h0000_3040, blk(32'hB000_0000), 1'b0, 2'd2);
        fill("fill_4040", 32'h0000_4040, blk(32'hC000_0000), 1'b0, 2'd3);
        rd_hit("read_1040", 32'h0000_1040, 32'h1111_1111);
        issue(OP_FILL, 32'h0000_5040, 32'h0, 4'h0, blk(32'hD000_0000), 1'b1,
              mk("fill_5040_lru", 1'b0, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2040, 1'b0, 128'h0));
        rd_miss("read_2040_evicted", 32'h0000_2040, 2'd2);
        wr("write_miss_6044", 32'h0000_6044, 32'h1234_5678, 4'b1111, 1'b0, 2'd2);
        rd_miss("read_6044", 32'h0000_6044, 2'd2);

        do_reset();
        fill("s2_fill_1040", 32'h0000_1040, B1, 1'b0, 2'd0);
        fill("s2_fill_2040", 32'h0000_2040, blk(32'hA000_0000), 1'b0, 2'd1);
        fill("s2_fill_3040", 32'h0000_3040, blk(32'hB000_0000), 1'b0, 2'd2);
        fill("s2_fill_4040", 32'h0000_4040, blk(32'hC000_0000), 1'b0, 2'd3);
        wr("s2_write_1044", 32'h0000_1044, 32'hDEAD_BEEF, 4'b0011, 1'b1, 2'd0);
        rd_hit("s2_read_2040", 32'h0000_2040, 32'hA000_0000);
        rd_hit("s2_read_3040", 32'h0000_3040, 32'hB000_0000);
        rd_hit("s2_read_4040", 32'h0000_4040, 32'hC000_0000);
        issue(OP_FILL, 32'h0000_5040, 32'h0, 4'h0, blk(32'hD000_0000), 1'b1,
              mk("fill_5040_dirty", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1040, 1'b1,
                 {32'h4444_4444, 32'h3333_3333, 32'h2222_BEEF, 32'h1111_1111}));
        rd_miss("s2_read_1040", 32'h0000_1040, 2'd1);
        rd_hit("s2_read_5044", 32'h0000_5044, 32'hD000_0001);
        wr("s2_write_2040", 32'h0000_2040, 32'h5555_5555, 4'b1111, 1'b1, 2'd1);

        issue(OP_INV, 32'h0, 32'h0, 4'h0, 128'h0, 1'b1,
              mk("inv_resp", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0));
        for (int k = 1; k <= NS; k++) begin
            chk("walk_ready", 128'(ready), 128'd0);
            chk("walk_resp_valid", 128'(resp_valid), 128'(k == NS));
            if (k == 3) begin
                op = OP_FILL; addr = 32'h0000_7040; fill_data = blk(32'hE000_0000); op_valid = 1'b1;
            end else begin
                op_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("ready_after_walk", 128'(ready), 128'd1);
        rd_miss("post_inv_1040", 32'h0000_1040, 2'd0);
        rd_miss("post_inv_2040", 32'h0000_2040, 2'd0);
        rd_miss("post_inv_ignored_fill", 32'h0000_7040, 2'd0);

        fill("pre_rst_fill_1040", 32'h0000_1040, B1, 1'b0, 2'd0);
        rd_hit("pre_rst_read_1040", 32'h0000_1040, 32'h1111_1111);
        issue(OP_INV, 32'h0, 32'h0, 4'h0, 128'h0, 1'b0,
              mk("inv_aborted", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0));
        for (int k = 1; k <= 4; k++) begin
            chk("walk2_ready", 128'(ready), 128'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midwalk_rst_ready", 128'(ready), 128'd1);
        chk("midwalk_rst_resp_valid", 128'(resp_valid), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midwalk_release_ready", 128'(ready), 128'd1);
        rd_miss("post_rst_1040", 32'h0000_1040, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/assoc_cache_array.md
# assoc_cache_array

Parametrised N-way set-associative cache data/tag array with multi-word blocks, byte-masked word writes, per-line dirty bits, true-LRU replacement, dirty-victim eviction reporting and a sequential invalidate-all walker. Sits between the core load/store path and the memory-side refill logic. It extends the single-word, valid-only array with dirty tracking, LRU victim choice and a registered response stage. Misses never allocate; the external controller issues FILL after fetching the block.

## Interface
- ADDR_SIZE, 32, byte address width
- NUM_SETS, 16, sets (power of 2, >=2)
- NUM_WAYS, 4, ways (power of 2, >=2)
- WORDS_PER_BLOCK, 4, 32-bit words per block (power of 2, >=1)
- Derived: OFF = 2+log2(WORDS_PER_BLOCK); SET = log2(NUM_SETS); TAG = ADDR_SIZE-SET-OFF; addr = {tag, set, word, 2'b00}

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- op_valid  in  1  request strobe
- op  in  2  00 READ, 01 WRITE, 10 FILL, 11 INVALIDATE_ALL
- addr  in  ADDR_SIZE  byte address (low 2 bits ignored)
- wdata  in  32  WRITE data word
- wstrb  in  4  WRITE byte enables
- fill_data  in  32*WORDS_PER_BLOCK  FILL block, word 0 in bits [31:0]
- ready  out  1  request accepted when op_valid && ready
- resp_valid  out  1  one-cycle response pulse
- hit  out  1  lookup hit
- rdata  out  32  READ word
- victim_way  out  log2(NUM_WAYS)  way chosen/used for replacement
- evict_valid  out  1  replaced/victim line is valid and dirty
- evict_addr  out  ADDR_SIZE  {victim tag, set, OFF zeros}
- evict_data  out  32*WORDS_PER_BLOCK  victim block

## Operation
- State per line: data, tag, valid, dirty, age (log2(NUM_WAYS) bits); ages within a set are always a permutation of 0..NUM_WAYS-1, 0 = MRU.
- Victim: lowest-index invalid way; if all valid, way with age NUM_WAYS-1.
- LRU touch of way w: lines with age < age[w] increment; age[w] <= 0; others unchanged.
- READ hit: rdata = addressed word, touch. Miss: hit=0, victim_way/evict_* report victim; no state change.
- WRITE hit: bytes with wstrb=1 updated, dirty<=1, touch. Miss: no allocate, hit=0, victim reported, no state change.
- FILL, tag absent: victim line <= fill_data, tag, valid=1, dirty=0, touch; hit=0; evict_* = old victim contents, evict_valid = old valid && dirty.
- FILL, tag present: overwrite hitting way, dirty<=0, touch; hit=1, victim_way=hit way, evict_valid=0.
- INVALIDATE_ALL: FSM IDLE -> CLEAR; CLEAR walks set 0..NUM_SETS-1, one set/cycle, clearing valid and dirty and setting age[w]=w; dirty data discarded (controller writes back first). After last set -> IDLE.
- rdata/evict_* don't-care when not meaningful for the op; resp_valid, hit, evict_valid held 0 when resp_valid=0.

## Timing
- Reset (async, immediate): all valid/dirty 0, age[w]=w in every set, FSM IDLE, resp_valid=0, hit=0, rdata=0, victim_way=0, evict_valid=0, evict_addr=0, evict_data=0; ready=1 (ready = FSM==IDLE).
- READ/WRITE/FILL: accepted in cycle T, array/LRU update at edge ending T, response registered and visible in T+1 for exactly one cycle. Back-to-back ops every cycle; op in T+1 sees T's update.
- INVALIDATE_ALL accepted in T: ready=0 during T+1..T+NUM_SETS; resp_valid=1 (hit=0) in T+NUM_SETS; ready=1 in T+NUM_SETS+1.
- op_valid while ready=0 ignored, no response.
- Reset mid-walk: FSM to IDLE, all lines invalid, ready=1 on release.

## Test plan
- Reset, READ 0x0000_1040 -> T+1: resp_valid=1, hit=0, victim_way=0, evict_valid=0.
- FILL 0x0000_1040 words {0x11111111,0x22222222,0x33333333,0x44444444}; READ 0x0000_1048 -> hit=1, rdata=0x33333333.
- WRITE 0x0000_1044 wdata 0xDEADBEEF wstrb 0011 -> hit=1; READ 0x1044 -> 0x2222BEEF.
- FILL 0x1040,0x2040,0x3040,0x4040 (ways 0-3, set 4), READ 0x1040, FILL 0x5040 -> victim_way=1, evict_valid=0, evict_addr=0x0000_2040.
- Dirty way 0 (WRITE 0x1044), READ 0x2040,0x3040,0x4040, FILL 0x5040 -> victim_way=0, evict_valid=1, evict_addr=0x0000_1040, evict_data word1=0x2222BEEF.
- INVALIDATE_ALL -> ready low 16 cycles, resp_valid on 16th, then READ 0x1040 hit=0; repeat with rst at cycle 5 of walk -> ready=1 after release, READ 0x1040 hit=0.
